proc_mem_arbiter: RTL and testbench
===================================

PROC_MEM_ARBITER -- requirements
Module: proc_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, memory word address width.
REQ-002 Parameter DATA_W, 16, memory word width.
REQ-003 Parameter TIMEOUT, 15, max cycles mem_req waits for mem_ack before abort; legal range 1..255.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req, if_addr  in  1, ADDR_W  instruction-fetch request and word address.
REQ-007 if_done, if_err, if_rdata  out  1, 1, DATA_W  fetch completion pulse, abort flag, read word.
REQ-008 dm_req, dm_we, dm_addr, dm_wdata  in  1, 1, ADDR_W, DATA_W  data-memory request, write enable, address, write word.
REQ-009 dm_done, dm_err, dm_rdata  out  1, 1, DATA_W  data completion pulse, abort flag, read word.
REQ-010 mem_req, mem_we, mem_addr, mem_wdata  out  1, 1, ADDR_W, DATA_W  single-port memory command.
REQ-011 mem_ack, mem_rdata  in  1, DATA_W  memory completion strobe, read word valid with mem_ack.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, SERVE_IF, SERVE_DM, DONE; all outputs registered.
REQ-014 IDLE: only if_req -> SERVE_IF; only dm_req -> SERVE_DM; neither -> stay.
REQ-015 IDLE with both requests: grant the requester not served last (round-robin last_grant flag); last_grant updates on each grant.
REQ-016 On grant, latch address, we (0 for fetch), wdata and owner; requester inputs are ignored afterwards.
REQ-017 mem_req rises the cycle after the grant decision (request in cycle N -> mem_req high in N+1), held with stable fields until mem_ack or timeout.
REQ-018 mem_ack sampled high while mem_req high: mem_req low next cycle, FSM -> DONE; read data captured into owner's rdata register.
REQ-019 DONE: owner's done pulses exactly one cycle, err=0; FSM -> IDLE; new grant earliest next cycle (min 3-cycle spacing between mem_req rises with mem_ack in first cycle).
REQ-020 Writes: owner rdata unchanged; done still pulses.
REQ-021 Timeout: 8-bit wait counter clears on grant, increments each cycle mem_req high without mem_ack; reaching TIMEOUT -> mem_req low, DONE with owner err=1 for the done cycle, rdata unchanged.
REQ-022 mem_ack in the same cycle the counter reaches TIMEOUT: ack wins, err=0.
REQ-023 mem_ack while mem_req low: ignored, no state change.
REQ-024 Requester dropping req mid-transaction: transaction still completes and done still pulses.
REQ-025 Non-owner request during a transaction: held off (no done), served at next IDLE evaluation.
REQ-026 if_err/dm_err high only with its done; low otherwise.

Reset
REQ-027 rst high at a posedge: state IDLE, mem_req/mem_we/busy/if_done/dm_done/if_err/dm_err 0, mem_addr/mem_wdata/if_rdata/dm_rdata 0, counter 0, last_grant=DM (so first contended grant goes to IF).
REQ-028 Reset mid-transaction aborts it without done pulse; mem_req low the cycle after reset is sampled; mem_ack during reset ignored.

Structure
REQ-029 Shared package proc_mem_arb_package: state enum, owner enum {OWN_IF, OWN_DM}, ADDR_W/DATA_W defaults, counter width constant.
REQ-030 One sub-module proc_mem_arb_timer: wait counter with clear, enable, TIMEOUT compare, expired output.

Verification
REQ-031 if_req=1, if_addr=0x10, mem_ack one cycle after mem_req, mem_rdata=0x7A05 -> if_done pulse one cycle, if_rdata=0x7A05, if_err=0, mem_we=0.
REQ-032 dm_req, dm_we=1, dm_addr=0x22, dm_wdata=0x00FF -> mem_addr=0x22, mem_wdata=0x00FF, mem_we=1 held until ack; dm_done pulse, dm_rdata unchanged.
REQ-033 if_req and dm_req both held after reset -> grants IF, DM, IF, DM in order; no done on the waiting side.
REQ-034 TIMEOUT=15, dm read, mem_ack never -> mem_req high exactly 15 cycles, then dm_done=1 and dm_err=1 together; ack on cycle 15 instead -> dm_err=0.
REQ-035 rst asserted two cycles into an SERVE_IF wait -> no if_done, mem_req 0 and busy 0 one cycle after reset sampled; subsequent dm request served normally.

Source files
------------

// File: rtl/proc_mem_arb_package.sv
// Shared types and constants for the processor memory arbiter.
package proc_mem_arb_package;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE_IF,
    ST_SERVE_DM,
    ST_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

endpackage

// File: rtl/proc_mem_arbiter_if.sv
// Bundle of requester (fetch/data) and memory-side signals around the arbiter.
interface proc_mem_arbiter_if
  import proc_mem_arb_package::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic              dm_err;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output if_done, if_err, if_rdata, dm_done, dm_err, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  // Environment view (requesters plus memory model)
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  if_done, if_err, if_rdata, dm_done, dm_err, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/proc_mem_arb_timer.sv
// Memory wait counter; expired_c flags the cycle in which the count reaches TIMEOUT.
module proc_mem_arb_timer
  import proc_mem_arb_package::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fires while counting the final cycle, so the abort lands on the TIMEOUT-th wait cycle
  assign expired_c = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and data requesters.
module proc_mem_arbiter
  import proc_mem_arb_package::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  proc_mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            last_grant_q, last_grant_d;
  owner_e            owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic              if_err_q, if_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dm_done_q, dm_done_d;
  logic              dm_err_q, dm_err_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              busy_q, busy_d;

  logic grant_if_c;
  logic grant_dm_c;
  logic ack_c;
  logic tmr_clr_c;
  logic tmr_en_c;
  logic tmr_expired_c;

  // Contended requests go to whoever was not granted last
  assign grant_if_c = bus.if_req && (!bus.dm_req || (last_grant_q == OWN_DM));
  assign grant_dm_c = bus.dm_req && !grant_if_c;
  assign ack_c      = bus.mem_ack && mem_req_q;
  assign tmr_en_c   = mem_req_q && !bus.mem_ack;

  proc_mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr_c),
    .en        (tmr_en_c),
    .expired_c (tmr_expired_c)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_done_d    = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_done_d    = 1'b0;
    dm_err_d     = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    tmr_clr_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_if_c) begin
          state_d      = ST_SERVE_IF;
          owner_d      = OWN_IF;
          last_grant_d = OWN_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          tmr_clr_c    = 1'b1;
        end else if (grant_dm_c) begin
          state_d      = ST_SERVE_DM;
          owner_d      = OWN_DM;
          last_grant_d = OWN_DM;
          mem_req_d    = 1'b1;
          mem_we_d     = bus.dm_we;
          mem_addr_d   = bus.dm_addr;
          mem_wdata_d  = bus.dm_wdata;
          tmr_clr_c    = 1'b1;
        end
      end
      ST_SERVE_IF, ST_SERVE_DM: begin
        // An ack in the expiring cycle still completes normally
        if (ack_c) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (owner_q == OWN_IF) begin
            if_done_d = 1'b1;
            if (!mem_we_q) if_rdata_d = bus.mem_rdata;
          end else begin
            dm_done_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
          end
        end else if (tmr_expired_c) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (owner_q == OWN_IF) begin
            if_done_d = 1'b1;
            if_err_d  = 1'b1;
          end else begin
            dm_done_d = 1'b1;
            dm_err_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_DM;
      owner_q      <= OWN_IF;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_done_q    <= 1'b0;
      dm_err_q     <= 1'b0;
      dm_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_done_q    <= if_done_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      dm_done_q    <= dm_done_d;
      dm_err_q     <= dm_err_d;
      dm_rdata_q   <= dm_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed bench for proc_mem_arbiter: fetch, write, round-robin, timeout and reset abort.
module tb_proc_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  proc_mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  proc_mem_arbiter #(
    .ADDR_W  (8),
    .DATA_W  (16),
    .TIMEOUT (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();
    chk("rst_mem_req",  32'(bus.mem_req),  32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_if_done",  32'(bus.if_done),  32'd0);
    chk("rst_dm_done",  32'(bus.dm_done),  32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
    rst = 1'b0;
    tick();

    // Instruction fetch, ack one cycle after mem_req rises
    bus.if_req    = 1'b1;
    bus.if_addr   = 8'h10;
    bus.mem_rdata = 16'h7A05;
    tick();
    chk("if_mem_req",  32'(bus.mem_req),  32'd1);
    chk("if_mem_addr", 32'(bus.mem_addr), 32'h10);
    chk("if_mem_we",   32'(bus.mem_we),   32'd0);
    chk("if_busy",     32'(bus.busy),     32'd1);
    bus.if_req = 1'b0;
    tick();
    chk("if_wait_req",  32'(bus.mem_req), 32'd1);
    chk("if_wait_done", 32'(bus.if_done), 32'd0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("if_done",      32'(bus.if_done),  32'd1);
    chk("if_rdata",     32'(bus.if_rdata), 32'h7A05);
    chk("if_err",       32'(bus.if_err),   32'd0);
    chk("if_req_drop",  32'(bus.mem_req),  32'd0);
    tick();
    chk("if_done_pulse", 32'(bus.if_done), 32'd0);
    chk("if_idle_busy",  32'(bus.busy),    32'd0);

    // Data write; requester fields change after grant and must be ignored
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b1;
    bus.dm_addr   = 8'h22;
    bus.dm_wdata  = 16'h00FF;
    bus.mem_rdata = 16'hBEEF;
    tick();
    chk("wr_mem_req",   32'(bus.mem_req),   32'd1);
    chk("wr_mem_we",    32'(bus.mem_we),    32'd1);
    chk("wr_mem_addr",  32'(bus.mem_addr),  32'h22);
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'h00FF);
    bus.dm_req   = 1'b0;
    bus.dm_addr  = 8'h33;
    bus.dm_wdata = 16'h1234;
    tick();
    chk("wr_hold_addr",  32'(bus.mem_addr),  32'h22);
    chk("wr_hold_wdata", 32'(bus.mem_wdata), 32'h00FF);
    chk("wr_hold_we",    32'(bus.mem_we),    32'd1);
    chk("wr_no_done",    32'(bus.dm_done),   32'd0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("wr_done",   32'(bus.dm_done),  32'd1);
    chk("wr_err",    32'(bus.dm_err),   32'd0);
    chk("wr_rdata",  32'(bus.dm_rdata), 32'd0);
    chk("wr_if_rd",  32'(bus.if_rdata), 32'h7A05);
    tick();
    chk("wr_done_pulse", 32'(bus.dm_done), 32'd0);

    // Reset, then both requesters contend with ack held high continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_if_rdata", 32'(bus.if_rdata), 32'd0);
    bus.if_req    = 1'b1;
    bus.if_addr   = 8'h01;
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 8'h02;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      logic exp_if;
      exp_if = ((i % 2) == 0);
      tick();
      chk("rr_mem_req",  32'(bus.mem_req),  32'd1);
      chk("rr_mem_addr", 32'(bus.mem_addr), exp_if ? 32'h01 : 32'h02);
      tick();
      chk("rr_if_done",  32'(bus.if_done),  32'(exp_if));
      chk("rr_dm_done",  32'(bus.dm_done),  32'(!exp_if));
      tick();
      chk("rr_gap_req",  32'(bus.mem_req),  32'd0);
      chk("rr_gap_done", 32'(bus.if_done | bus.dm_done), 32'd0);
    end
    bus.if_req  = 1'b0;
    bus.dm_req  = 1'b0;
    bus.mem_ack = 1'b0;
    chk("rr_dm_rdata", 32'(bus.dm_rdata), 32'h5555);
    tick();
    chk("rr_idle_busy", 32'(bus.busy), 32'd0);

    // Data read that never gets acked: abort after exactly 15 mem_req cycles
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 8'h40;
    bus.mem_rdata = 16'h9999;
    tick();
    bus.dm_req = 1'b0;
    chk("to_req_c1", 32'(bus.mem_req), 32'd1);
    for (int k = 1; k < 15; k++) begin
      tick();
      chk("to_req_hold", 32'(bus.mem_req), 32'd1);
      chk("to_no_done",  32'(bus.dm_done), 32'd0);
    end
    tick();
    chk("to_req_low", 32'(bus.mem_req),  32'd0);
    chk("to_done",    32'(bus.dm_done),  32'd1);
    chk("to_err",     32'(bus.dm_err),   32'd1);
    chk("to_rdata",   32'(bus.dm_rdata), 32'h5555);
    tick();
    chk("to_done_pulse", 32'(bus.dm_done), 32'd0);
    chk("to_err_pulse",  32'(bus.dm_err),  32'd0);

    // Same read, ack arrives in the 15th cycle: ack wins
    bus.dm_req    = 1'b1;
    bus.mem_rdata = 16'h0ACE;
    tick();
    bus.dm_req = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    chk("ta_req_c15", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("ta_done",  32'(bus.dm_done),  32'd1);
    chk("ta_err",   32'(bus.dm_err),   32'd0);
    chk("ta_rdata", 32'(bus.dm_rdata), 32'h0ACE);
    tick();

    // Reset two cycles into a fetch wait aborts it silently
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h05;
    tick();
    bus.if_req = 1'b0;
    chk("ra_req", 32'(bus.mem_req), 32'd1);
    tick();
    rst         = 1'b1;
    bus.mem_ack = 1'b1;
    tick();
    chk("ra_mem_req", 32'(bus.mem_req), 32'd0);
    chk("ra_busy",    32'(bus.busy),    32'd0);
    chk("ra_if_done", 32'(bus.if_done), 32'd0);
    rst         = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    chk("ra_post_done", 32'(bus.if_done), 32'd0);
    chk("ra_post_req",  32'(bus.mem_req), 32'd0);
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 8'h66;
    tick();
    bus.dm_req = 1'b0;
    chk("ra_dm_req",  32'(bus.mem_req),  32'd1);
    chk("ra_dm_addr", 32'(bus.mem_addr), 32'h66);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h1357;
    tick();
    bus.mem_ack = 1'b0;
    chk("ra_dm_done",  32'(bus.dm_done),  32'd1);
    chk("ra_dm_rdata", 32'(bus.dm_rdata), 32'h1357);
    chk("ra_if_quiet", 32'(bus.if_done),  32'd0);
    tick();
    chk("ra_end_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
